// File: rtl/play_stream_engine.sv
// SDRAM-to-audio playback engine: reads a length header and N samples into a prefetch FIFO,
// then streams them to a valid/ready sink with sample repeat (slow), address skip (fast) and looping.
module play_stream_engine #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SPD_W      = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_base,
  input  logic              play_fast,
  input  logic [SPD_W-1:0]  play_factor,
  input  logic              play_loop,
  input  logic              play_pause,
  input  logic              play_stop,
  output logic              play_done,
  output logic              play_busy,
  output logic              play_read,
  output logic [ADDR_W-1:0] play_addr,
  input  logic [DATA_W-1:0] play_readdata,
  input  logic              play_sdram_finished,
  output logic              play_audio_valid,
  output logic [DATA_W-1:0] play_audio_data,
  input  logic              play_audio_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_FETCH, S_DRAIN} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_base;
  logic               r_fast;
  logic [SPD_W-1:0]   r_factor;
  logic               r_loop;
  logic [ADDR_W:0]    r_addr;
  logic [ADDR_W:0]    r_end;
  logic               r_read;
  logic               r_done;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               r_hold_full;
  logic [SPD_W-1:0]   r_rep_left;
  logic               r_valid;
  logic [DATA_W-1:0]  r_data;

  logic               w_fin;
  logic               w_push;
  logic               w_accept;
  logic               w_last;
  logic               w_pop;
  logic [ADDR_W:0]    w_step;
  logic [ADDR_W:0]    w_next_addr;
  logic [ADDR_W:0]    w_first_addr;
  logic [ADDR_W:0]    w_hdr_len;
  logic [SPD_W-1:0]   w_start_factor;

  // Completion pulses are only meaningful while a request is outstanding.
  assign w_fin          = play_sdram_finished & r_read;
  assign w_push         = (r_state == S_FETCH) && w_fin && !play_stop;
  assign w_accept       = r_valid && play_audio_ready;
  assign w_last         = w_accept && (r_rep_left == SPD_W'(1));
  assign w_pop          = (!r_hold_full || w_last) && (r_count != '0) && !play_stop;
  assign w_step         = r_fast ? {{(ADDR_W+1-SPD_W){1'b0}}, r_factor} : (ADDR_W+1)'(1);
  assign w_next_addr    = r_addr + w_step;
  assign w_first_addr   = {1'b0, r_base} + (ADDR_W+1)'(1);
  assign w_hdr_len      = {1'b0, play_readdata[ADDR_W-1:0]};
  assign w_start_factor = (play_factor == '0) ? SPD_W'(1) : play_factor;

  assign play_done        = r_done;
  assign play_busy        = (r_state != S_IDLE);
  assign play_read        = r_read;
  assign play_addr        = r_addr[ADDR_W-1:0];
  assign play_audio_valid = r_valid;
  assign play_audio_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_fast   <= 1'b0;
      r_factor <= SPD_W'(1);
      r_loop   <= 1'b0;
      r_addr   <= '0;
      r_end    <= '0;
      r_read   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (play_stop) begin
        r_state <= S_IDLE;
        r_read  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (play_start) begin
              r_base   <= play_base;
              r_fast   <= play_fast;
              r_factor <= w_start_factor;
              r_loop   <= play_loop;
              r_addr   <= {1'b0, play_base};
              r_read   <= 1'b1;
              r_state  <= S_HDR;
            end
          end
          S_HDR: begin
            if (w_fin) begin
              r_read <= 1'b0;
              if (w_hdr_len == '0) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_end   <= {1'b0, r_base} + w_hdr_len;
                r_addr  <= w_first_addr;
                r_state <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            if (w_fin) begin
              r_read <= 1'b0;
              if (w_next_addr > r_end) begin
                if (r_loop) r_addr <= w_first_addr;
                else        r_state <= S_DRAIN;
              end else begin
                r_addr <= w_next_addr;
              end
            end else if (!r_read && (r_count < FULL_CNT)) begin
              r_read <= 1'b1;
            end
          end
          S_DRAIN: begin
            if ((r_count == '0) && !r_hold_full) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= play_readdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || play_stop) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Holding register doubles as the sink interface; it repeats a sample r_rep_left times.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_full <= 1'b0;
      r_rep_left  <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
    end else if (play_stop) begin
      r_hold_full <= 1'b0;
      r_valid     <= 1'b0;
    end else if (w_pop) begin
      r_data      <= r_mem[r_rd_ptr];
      r_hold_full <= 1'b1;
      r_rep_left  <= r_fast ? SPD_W'(1) : r_factor;
      r_valid     <= !play_pause;
    end else if (w_last) begin
      r_hold_full <= 1'b0;
      r_valid     <= 1'b0;
    end else if (w_accept) begin
      r_rep_left <= r_rep_left - SPD_W'(1);
      r_valid    <= !play_pause;
    end else if (r_hold_full && !r_valid && !play_pause) begin
      r_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_play_stream_engine.sv
// Directed bench for play_stream_engine with a fixed-latency SDRAM responder and a sink monitor.
module tb_play_stream_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play_start = 1'b0;
  logic [22:0] play_base = '0;
  logic        play_fast = 1'b0;
  logic [2:0]  play_factor = 3'd1;
  logic        play_loop = 1'b0;
  logic        play_pause = 1'b0;
  logic        play_stop = 1'b0;
  logic        play_done;
  logic        play_busy;
  logic        play_read;
  logic [22:0] play_addr;
  logic [31:0] play_readdata = '0;
  logic        play_sdram_finished = 1'b0;
  logic        play_audio_valid;
  logic [31:0] play_audio_data;
  logic        play_audio_ready = 1'b1;

  play_stream_engine dut (
    .i_clk(clk), .i_rst(rst),
    .play_start(play_start), .play_base(play_base), .play_fast(play_fast),
    .play_factor(play_factor), .play_loop(play_loop), .play_pause(play_pause),
    .play_stop(play_stop), .play_done(play_done), .play_busy(play_busy),
    .play_read(play_read), .play_addr(play_addr), .play_readdata(play_readdata),
    .play_sdram_finished(play_sdram_finished),
    .play_audio_valid(play_audio_valid), .play_audio_data(play_audio_data),
    .play_audio_ready(play_audio_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] mem [0:1023];
  logic [22:0] rd_log [$];
  logic [31:0] samp [$];
  int          mem_cnt = 0;
  int          fin_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          stab_err = 0;
  logic        valid_seen = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM responder: completion two falling edges after the request is seen.
  always @(negedge clk) begin
    if (play_sdram_finished) begin
      play_sdram_finished = 1'b0;
      mem_cnt = 0;
    end else if (play_read && !rst) begin
      mem_cnt++;
      if (mem_cnt == 2) begin
        play_sdram_finished = 1'b1;
        play_readdata = mem[play_addr[9:0]];
        rd_log.push_back(play_addr);
        fin_cyc = cyc;
        mem_cnt = 0;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (play_done) begin done_cnt++; done_cyc = cyc; end
      if (play_audio_valid) valid_seen = 1'b1;
      if (prev_hold && (!play_audio_valid || play_audio_data !== prev_data)) stab_err++;
      prev_hold = play_audio_valid && !play_audio_ready;
      prev_data = play_audio_data;
      if (play_audio_valid && play_audio_ready) samp.push_back(play_audio_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_clip(input logic [22:0] base, input logic fast, input logic [2:0] f,
                            input logic lp);
    rd_log.delete();
    samp.delete();
    @(posedge clk); #1;
    play_base = base; play_fast = fast; play_factor = f; play_loop = lp;
    play_start = 1'b1;
    @(posedge clk); #1;
    play_start = 1'b0;
    check("start_lat", play_read, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    #1;
    check(tag, done_cnt - d0, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 + i;
    mem[10'h100] = 32'd4;
    for (int i = 0; i < 4; i++) mem[10'h101 + i] = 32'hA0 + i;
    mem[10'h200] = 32'd2; mem[10'h201] = 32'hB0; mem[10'h202] = 32'hB1;
    mem[10'h180] = 32'd5;
    for (int i = 0; i < 5; i++) mem[10'h181 + i] = 32'hC0 + i;
    mem[10'h1F0] = 32'd0;
    mem[10'h300] = 32'd8;
    for (int i = 0; i < 8; i++) mem[10'h301 + i] = 32'hD0 + i;
    mem[10'h280] = 32'd2; mem[10'h281] = 32'hE0; mem[10'h282] = 32'hE1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_read", play_read, 0);
    check("rst_addr", play_addr, 0);
    check("rst_valid", play_audio_valid, 0);
    check("rst_data", play_audio_data, 0);
    check("rst_done", play_done, 0);
    check("rst_busy", play_busy, 0);
    rst = 1'b0;

    // Slow F=1, N=4
    $display("clip base=100 slow F=1 N=4");
    start_clip(23'h100, 1'b0, 3'd1, 1'b0);
    wait_done("done_n4", 300);
    check("n4_reads", rd_log.size(), 5);
    for (int i = 0; i < 5 && i < rd_log.size(); i++) check("n4_addr", rd_log[i], 23'h100 + i);
    check("n4_nsamp", samp.size(), 4);
    for (int i = 0; i < 4 && i < samp.size(); i++) check("n4_samp", samp[i], 32'hA0 + i);
    check("n4_busy", play_busy, 0);

    // Slow F=3, N=2
    $display("clip base=200 slow F=3 N=2");
    start_clip(23'h200, 1'b0, 3'd3, 1'b0);
    wait_done("done_f3", 300);
    repeat (10) @(posedge clk);
    #1;
    check("f3_nsamp", samp.size(), 6);
    for (int i = 0; i < 6 && i < samp.size(); i++) check("f3_samp", samp[i], (i < 3) ? 32'hB0 : 32'hB1);
    check("f3_valid", play_audio_valid, 0);

    // Fast F=2, N=5
    $display("clip base=180 fast F=2 N=5");
    start_clip(23'h180, 1'b1, 3'd2, 1'b0);
    wait_done("done_fast", 300);
    check("fast_reads", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      check("fast_a0", rd_log[0], 23'h180);
      check("fast_a1", rd_log[1], 23'h181);
      check("fast_a2", rd_log[2], 23'h183);
      check("fast_a3", rd_log[3], 23'h185);
    end
    check("fast_nsamp", samp.size(), 3);
    for (int i = 0; i < 3 && i < samp.size(); i++) check("fast_samp", samp[i], 32'hC0 + 2 * i);

    // N=0
    $display("clip base=1F0 N=0");
    valid_seen = 1'b0;
    start_clip(23'h1F0, 1'b0, 3'd1, 1'b0);
    wait_done("done_n0", 100);
    check("n0_lat", done_cyc - fin_cyc, 1);
    check("n0_valid", valid_seen, 0);
    check("n0_busy", play_busy, 0);

    // Backpressure, N=8
    $display("clip base=300 N=8 ready=0");
    stab_err = 0;
    play_audio_ready = 1'b0;
    start_clip(23'h300, 1'b0, 3'd1, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("bp_reads", rd_log.size(), 6);
    check("bp_valid", play_audio_valid, 1);
    check("bp_data", play_audio_data, 32'hD0);
    play_audio_ready = 1'b1;
    wait_done("done_bp", 300);
    check("bp_nsamp", samp.size(), 8);
    for (int i = 0; i < 8 && i < samp.size(); i++) check("bp_samp", samp[i], 32'hD0 + i);
    check("bp_stable", stab_err, 0);

    // Loop, stop on the fifth accepted sample
    $display("clip base=280 loop N=2 stop after 5");
    begin
      int guard;
      int d0;
      guard = 0;
      start_clip(23'h280, 1'b0, 3'd1, 1'b1);
      #1;
      while (!(samp.size() == 4 && play_audio_valid && play_audio_ready) && guard < 300) begin
        @(posedge clk); #2;
        guard++;
      end
      check("loop_reach", guard < 300, 1);
      d0 = done_cnt;
      play_stop = 1'b1;
      @(posedge clk); #1;
      play_stop = 1'b0;
      check("stop_valid", play_audio_valid, 0);
      check("stop_read", play_read, 0);
      check("stop_done", play_done, 1);
      check("stop_busy", play_busy, 0);
      repeat (6) @(posedge clk);
      #1;
      check("loop_nsamp", samp.size(), 5);
      for (int i = 0; i < 5 && i < samp.size(); i++) check("loop_samp", samp[i], (i % 2 == 0) ? 32'hE0 : 32'hE1);
      check("loop_ndone", done_cnt - d0, 1);
    end

    // Stop while idle
    $display("stop in idle");
    @(posedge clk); #1;
    play_stop = 1'b1;
    @(posedge clk); #1;
    play_stop = 1'b0;
    check("idle_stop_done", play_done, 1);
    @(posedge clk); #1;
    check("idle_stop_pulse", play_done, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
